// File: rtl/wram_access_arbiter_pkg.sv
// rtl/wram_access_arbiter_pkg.sv - shared encodings and defaults for the WRAM access arbiter
package wram_access_arbiter_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STROBE = 2'd1,
        S_WAIT   = 2'd2,
        S_ACK    = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWNER_CPU = 1'b0,
        OWNER_DMA = 1'b1
    } owner_t;

    localparam int DEFAULT_MAX_DMA_BURST = 160;
    localparam int DEFAULT_READ_LATENCY  = 1;
    localparam int BURST_CNT_W           = 8;

endpackage

// File: rtl/wram_arb_pick.sv
// rtl/wram_arb_pick.sv - combinational winner selection between CPU and DMA requesters
module wram_arb_pick
    import wram_access_arbiter_pkg::*;
#(
    parameter int MAX_DMA_BURST = DEFAULT_MAX_DMA_BURST
) (
    input  logic                   cpu_req,
    input  logic                   dma_req,
    input  logic                   dma_lock,
    input  logic [BURST_CNT_W-1:0] burst_cnt,
    input  owner_t                 last_owner,
    output logic                   grant_valid,
    output owner_t                 grant_owner
);

    localparam logic [BURST_CNT_W-1:0] BURST_MAX = BURST_CNT_W'(MAX_DMA_BURST);

    always_comb begin
        grant_valid = cpu_req | dma_req;
        grant_owner = OWNER_CPU;
        if (dma_req && !cpu_req) begin
            grant_owner = OWNER_DMA;
        end else if (cpu_req && dma_req) begin
            // A saturated burst falls through to round-robin, which hands the CPU its one slot
            if (dma_lock && (burst_cnt < BURST_MAX)) begin
                grant_owner = OWNER_DMA;
            end else begin
                grant_owner = (last_owner == OWNER_DMA) ? OWNER_CPU : OWNER_DMA;
            end
        end
    end

endmodule

// File: rtl/wram_access_arbiter.sv
// rtl/wram_access_arbiter.sv - sequences CPU and DMA accesses onto the single WRAM router port
module wram_access_arbiter
    import wram_access_arbiter_pkg::*;
#(
    parameter int READ_LATENCY  = DEFAULT_READ_LATENCY,
    parameter int MAX_DMA_BURST = DEFAULT_MAX_DMA_BURST
) (
    input  logic        I_CLK,
    input  logic        I_RESET,
    input  logic        I_CPU_REQ,
    input  logic        I_CPU_WE,
    input  logic [15:0] I_CPU_ADDR,
    input  logic [7:0]  I_CPU_WDATA,
    output logic        O_CPU_ACK,
    output logic [7:0]  O_CPU_RDATA,
    input  logic        I_DMA_REQ,
    input  logic        I_DMA_WE,
    input  logic [15:0] I_DMA_ADDR,
    input  logic [7:0]  I_DMA_WDATA,
    output logic        O_DMA_ACK,
    output logic [7:0]  O_DMA_RDATA,
    input  logic        I_DMA_LOCK,
    output logic [15:0] O_WRAM_ADDR,
    output logic [7:0]  O_WRAM_WDATA,
    output logic        O_WRAM_WE_L,
    output logic        O_WRAM_RE_L,
    input  logic [7:0]  I_WRAM_RDATA,
    output logic        O_BUSY
);

    localparam logic [BURST_CNT_W-1:0] BURST_MAX = BURST_CNT_W'(MAX_DMA_BURST);
    localparam logic [2:0]             LAT_LAST  = 3'(READ_LATENCY - 1);

    arb_state_t             state;
    owner_t                 last_owner;
    logic                   acc_we;
    logic [2:0]             wait_cnt;
    logic [BURST_CNT_W-1:0] burst_cnt;

    logic                   grant_valid;
    owner_t                 grant_owner;
    logic                   sel_we;
    logic [15:0]            sel_addr;
    logic [7:0]             sel_wdata;

    wram_arb_pick #(
        .MAX_DMA_BURST(MAX_DMA_BURST)
    ) u_pick (
        .cpu_req    (I_CPU_REQ),
        .dma_req    (I_DMA_REQ),
        .dma_lock   (I_DMA_LOCK),
        .burst_cnt  (burst_cnt),
        .last_owner (last_owner),
        .grant_valid(grant_valid),
        .grant_owner(grant_owner)
    );

    always_comb begin
        sel_we    = I_CPU_WE;
        sel_addr  = I_CPU_ADDR;
        sel_wdata = I_CPU_WDATA;
        if (grant_owner == OWNER_DMA) begin
            sel_we    = I_DMA_WE;
            sel_addr  = I_DMA_ADDR;
            sel_wdata = I_DMA_WDATA;
        end
    end

    // last_owner doubles as the in-flight owner; it starts at DMA so the CPU wins the first tie
    always_ff @(posedge I_CLK or posedge I_RESET) begin
        if (I_RESET) begin
            state        <= S_IDLE;
            last_owner   <= OWNER_DMA;
            acc_we       <= 1'b0;
            wait_cnt     <= '0;
            burst_cnt    <= '0;
            O_WRAM_ADDR  <= '0;
            O_WRAM_WDATA <= '0;
            O_WRAM_WE_L  <= 1'b1;
            O_WRAM_RE_L  <= 1'b1;
            O_CPU_ACK    <= 1'b0;
            O_DMA_ACK    <= 1'b0;
            O_CPU_RDATA  <= '0;
            O_DMA_RDATA  <= '0;
            O_BUSY       <= 1'b0;
        end else begin
            O_CPU_ACK <= 1'b0;
            O_DMA_ACK <= 1'b0;
            if (!I_DMA_LOCK) begin
                burst_cnt <= '0;
            end

            case (state)
                S_IDLE: begin
                    if (grant_valid) begin
                        last_owner   <= grant_owner;
                        acc_we       <= sel_we;
                        O_WRAM_ADDR  <= sel_addr;
                        O_WRAM_WDATA <= sel_wdata;
                        O_WRAM_WE_L  <= ~sel_we;
                        O_WRAM_RE_L  <= sel_we;
                        O_BUSY       <= 1'b1;
                        state        <= S_STROBE;
                        if (grant_owner == OWNER_CPU) begin
                            burst_cnt <= '0;
                        end else if (I_DMA_LOCK && (burst_cnt < BURST_MAX)) begin
                            burst_cnt <= burst_cnt + 1'b1;
                        end
                    end
                end

                S_STROBE: begin
                    O_WRAM_WE_L <= 1'b1;
                    O_WRAM_RE_L <= 1'b1;
                    wait_cnt    <= '0;
                    state       <= S_WAIT;
                end

                S_WAIT: begin
                    if (wait_cnt == LAT_LAST) begin
                        state <= S_ACK;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                S_ACK: begin
                    // Read data is sampled here, READ_LATENCY cycles after the strobe rose
                    if (last_owner == OWNER_CPU) begin
                        O_CPU_ACK <= 1'b1;
                        if (!acc_we) begin
                            O_CPU_RDATA <= I_WRAM_RDATA;
                        end
                    end else begin
                        O_DMA_ACK <= 1'b1;
                        if (!acc_we) begin
                            O_DMA_RDATA <= I_WRAM_RDATA;
                        end
                    end
                    O_BUSY <= 1'b0;
                    state  <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wram_access_arbiter.sv
// tb/tb_wram_access_arbiter.sv - directed vector bench for wram_access_arbiter
module tb_wram_access_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we, dma_req, dma_we, dma_lock;
    logic [15:0] cpu_addr, dma_addr;
    logic [7:0]  cpu_wdata, dma_wdata, wram_rdata, wram_rdata3;

    logic        cpu_ack, dma_ack, wram_we_l, wram_re_l, busy;
    logic [7:0]  cpu_rdata, dma_rdata, wram_wdata;
    logic [15:0] wram_addr;

    logic        cpu_ack3, dma_ack3, wram_we_l3, wram_re_l3, busy3;
    logic [7:0]  cpu_rdata3, dma_rdata3, wram_wdata3;
    logic [15:0] wram_addr3;

    always #5 clk = ~clk;

    wram_access_arbiter #(.READ_LATENCY(1), .MAX_DMA_BURST(4)) dut (
        .I_CLK(clk), .I_RESET(rst),
        .I_CPU_REQ(cpu_req), .I_CPU_WE(cpu_we), .I_CPU_ADDR(cpu_addr), .I_CPU_WDATA(cpu_wdata),
        .O_CPU_ACK(cpu_ack), .O_CPU_RDATA(cpu_rdata),
        .I_DMA_REQ(dma_req), .I_DMA_WE(dma_we), .I_DMA_ADDR(dma_addr), .I_DMA_WDATA(dma_wdata),
        .O_DMA_ACK(dma_ack), .O_DMA_RDATA(dma_rdata), .I_DMA_LOCK(dma_lock),
        .O_WRAM_ADDR(wram_addr), .O_WRAM_WDATA(wram_wdata), .O_WRAM_WE_L(wram_we_l),
        .O_WRAM_RE_L(wram_re_l), .I_WRAM_RDATA(wram_rdata), .O_BUSY(busy)
    );

    wram_access_arbiter #(.READ_LATENCY(3), .MAX_DMA_BURST(4)) dut3 (
        .I_CLK(clk), .I_RESET(rst),
        .I_CPU_REQ(cpu_req), .I_CPU_WE(cpu_we), .I_CPU_ADDR(cpu_addr), .I_CPU_WDATA(cpu_wdata),
        .O_CPU_ACK(cpu_ack3), .O_CPU_RDATA(cpu_rdata3),
        .I_DMA_REQ(dma_req), .I_DMA_WE(dma_we), .I_DMA_ADDR(dma_addr), .I_DMA_WDATA(dma_wdata),
        .O_DMA_ACK(dma_ack3), .O_DMA_RDATA(dma_rdata3), .I_DMA_LOCK(dma_lock),
        .O_WRAM_ADDR(wram_addr3), .O_WRAM_WDATA(wram_wdata3), .O_WRAM_WE_L(wram_we_l3),
        .O_WRAM_RE_L(wram_re_l3), .I_WRAM_RDATA(wram_rdata3), .O_BUSY(busy3)
    );

    typedef struct {
        logic        dma;
        logic        we;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  rd;
        logic        mutate;
        logic [7:0]  exp_cpu_rdata;
        logic [7:0]  exp_dma_rdata;
    } vec_t;

    int checks = 0;
    int failures = 0;

    int          re_cnt, we_cnt;
    logic [15:0] re_addr, we_addr;
    logic [7:0]  we_data;

    always @(negedge clk) begin
        if (!wram_re_l) begin
            re_cnt  = re_cnt + 1;
            re_addr = wram_addr;
        end
        if (!wram_we_l) begin
            we_cnt  = we_cnt + 1;
            we_addr = wram_addr;
            we_data = wram_wdata;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; cpu_req = 1'b0; dma_req = 1'b0; dma_lock = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_access(input logic dma, input logic we, input logic [15:0] addr,
                              input logic [7:0] wdata, input logic [7:0] rd, input logic mutate,
                              output int ack_n, output int other_acks);
        @(negedge clk);
        re_cnt = 0; we_cnt = 0;
        wram_rdata = rd;
        if (dma) begin
            dma_we = we; dma_addr = addr; dma_wdata = wdata; dma_req = 1'b1;
        end else begin
            cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_req = 1'b1;
        end
        ack_n = 0; other_acks = 0;
        for (int n = 1; n <= 12 && ack_n == 0; n++) begin
            @(negedge clk);
            if (n == 1) begin
                check("busy_in_access", busy, 1);
                if (mutate) begin
                    if (dma) begin dma_wdata = ~wdata; dma_addr = 16'hFFFF; end
                    else begin cpu_wdata = ~wdata; cpu_addr = 16'hFFFF; end
                end
            end
            if (dma ? dma_ack : cpu_ack) ack_n = n;
            if (dma ? cpu_ack : dma_ack) other_acks++;
        end
        cpu_req = 1'b0; dma_req = 1'b0;
    endtask

    vec_t vecs[6];
    int   ack_n, other;
    int   grants[$];
    int   exp_b[9];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0; dma_lock = 0;
        wram_rdata = 0; wram_rdata3 = 0;
        re_cnt = 0; we_cnt = 0; re_addr = 0; we_addr = 0; we_data = 0;
        repeat (3) @(negedge clk);
        check("rst_we_l", wram_we_l, 1);
        check("rst_re_l", wram_re_l, 1);
        check("rst_addr", wram_addr, 0);
        check("rst_wdata", wram_wdata, 0);
        check("rst_acks", {cpu_ack, dma_ack}, 0);
        check("rst_rdata", {cpu_rdata, dma_rdata}, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;

        vecs[0] = '{1'b0, 1'b0, 16'hC123, 8'h00, 8'h5A, 1'b0, 8'h5A, 8'h00};
        vecs[1] = '{1'b1, 1'b0, 16'hFDFF, 8'h00, 8'hA5, 1'b0, 8'h5A, 8'hA5};
        vecs[2] = '{1'b0, 1'b1, 16'hC000, 8'h3C, 8'hFF, 1'b0, 8'h5A, 8'hA5};
        vecs[3] = '{1'b1, 1'b1, 16'hD010, 8'h77, 8'h12, 1'b1, 8'h5A, 8'hA5};
        vecs[4] = '{1'b0, 1'b0, 16'hE000, 8'h00, 8'h00, 1'b0, 8'h00, 8'hA5};
        vecs[5] = '{1'b1, 1'b0, 16'hC001, 8'h00, 8'hC3, 1'b0, 8'h00, 8'hC3};

        foreach (vecs[i]) begin
            run_access(vecs[i].dma, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].rd,
                       vecs[i].mutate, ack_n, other);
            check($sformatf("v%0d_ack_latency", i), ack_n, 4);
            check($sformatf("v%0d_other_ack", i), other, 0);
            check($sformatf("v%0d_re_cnt", i), re_cnt, vecs[i].we ? 0 : 1);
            check($sformatf("v%0d_we_cnt", i), we_cnt, vecs[i].we ? 1 : 0);
            if (vecs[i].we) begin
                check($sformatf("v%0d_we_addr", i), we_addr, vecs[i].addr);
                check($sformatf("v%0d_we_data", i), we_data, vecs[i].wdata);
            end else begin
                check($sformatf("v%0d_re_addr", i), re_addr, vecs[i].addr);
            end
            check($sformatf("v%0d_addr_hold", i), wram_addr, vecs[i].addr);
            check($sformatf("v%0d_cpu_rdata", i), cpu_rdata, vecs[i].exp_cpu_rdata);
            check($sformatf("v%0d_dma_rdata", i), dma_rdata, vecs[i].exp_dma_rdata);
        end

        // Round-robin with both requesters held, no lock
        do_reset();
        @(negedge clk);
        cpu_we = 0; dma_we = 0; cpu_addr = 16'hC100; dma_addr = 16'hD100;
        cpu_req = 1; dma_req = 1;
        grants.delete();
        for (int n = 0; n < 100 && grants.size() < 6; n++) begin
            @(negedge clk);
            if (cpu_ack) grants.push_back(0);
            if (dma_ack) grants.push_back(1);
        end
        cpu_req = 0; dma_req = 0;
        check("rr_count", grants.size(), 6);
        for (int i = 0; i < 6; i++)
            check($sformatf("rr_grant%0d", i), (i < grants.size()) ? grants[i] : 9, i % 2);

        // Locked DMA burst of 4, then one forced CPU slot
        do_reset();
        exp_b = '{1, 1, 1, 1, 0, 1, 1, 1, 1};
        @(negedge clk);
        dma_lock = 1; cpu_req = 1; dma_req = 1;
        grants.delete();
        for (int n = 0; n < 120 && grants.size() < 9; n++) begin
            @(negedge clk);
            if (cpu_ack) begin
                grants.push_back(0);
                check("burst_cnt_cleared", dut.burst_cnt, 0);
            end
            if (dma_ack) begin
                grants.push_back(1);
                if (grants.size() == 4) check("burst_cnt_full", dut.burst_cnt, 4);
            end
        end
        cpu_req = 0; dma_req = 0; dma_lock = 0;
        check("burst_count", grants.size(), 9);
        for (int i = 0; i < 9; i++)
            check($sformatf("burst_grant%0d", i), (i < grants.size()) ? grants[i] : 9, exp_b[i]);

        // Reset during WAIT of a CPU read
        do_reset();
        @(negedge clk);
        cpu_we = 0; cpu_addr = 16'hC200; wram_rdata = 8'h99; cpu_req = 1;
        @(negedge clk);
        @(negedge clk);
        rst = 1;
        #1;
        check("mid_rst_strobes", {wram_we_l, wram_re_l}, 2'b11);
        check("mid_rst_acks", {cpu_ack, dma_ack}, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_cpu_rdata", cpu_rdata, 0);
        cpu_req = 0;
        @(negedge clk);
        rst = 0;
        other = 0;
        repeat (10) begin
            @(negedge clk);
            if (cpu_ack || dma_ack) other++;
        end
        check("no_ack_after_rst", other, 0);
        run_access(1'b0, 1'b0, 16'hC200, 8'h00, 8'h99, 1'b0, ack_n, other);
        check("post_rst_ack_latency", ack_n, 4);
        check("post_rst_cpu_rdata", cpu_rdata, 8'h99);

        // READ_LATENCY=3: capture only what is present in the ACK-state cycle
        do_reset();
        @(negedge clk);
        wram_rdata3 = 8'h11; dma_we = 0; dma_addr = 16'hC3C3; dma_req = 1;
        ack_n = 0; other = 0;
        for (int n = 1; n <= 15 && ack_n == 0; n++) begin
            @(negedge clk);
            if (n == 1) begin
                check("lat3_busy", busy3, 1);
                check("lat3_strobes", {wram_we_l3, wram_re_l3}, 2'b10);
            end
            if (n == 4) wram_rdata3 = 8'h22;
            if (n == 5) wram_rdata3 = 8'h33;
            if (n == 6) wram_rdata3 = 8'h44;
            if (dma_ack3) ack_n = n;
            if (cpu_ack3) other++;
        end
        dma_req = 0;
        check("lat3_ack_latency", ack_n, 6);
        check("lat3_dma_rdata", dma_rdata3, 8'h33);
        check("lat3_addr", wram_addr3, 16'hC3C3);
        check("lat3_cpu_side", {other[7:0], cpu_rdata3, wram_wdata3}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wram_access_arbiter.md
Name: wram_access_arbiter

Overview:
- Shares the single working-RAM router port (banked WRAM, 0xC000–0xFDFF) between two requesters: the CPU memory path (port C) and the DMA engine (port D, OAM DMA / HDMA source reads).
- Sequences each access: issue strobe, wait a fixed read latency, capture read data, acknowledge.
- Sits between the memory router and the working memory bank. Addresses pass through unchanged; SVBK bank translation stays in the bank.

Parameters:
- READ_LATENCY, 1, cycles from strobe deassertion to valid I_WRAM_RDATA (1..7).
- MAX_DMA_BURST, 160, maximum consecutive locked DMA grants before one CPU slot is forced (1..255).

Ports:
- I_CLK  in  1  system clock
- I_RESET  in  1  asynchronous, active-high reset
- I_CPU_REQ  in  1  CPU access request, held until ack
- I_CPU_WE  in  1  1 = write, 0 = read
- I_CPU_ADDR  in  16  CPU address
- I_CPU_WDATA  in  8  CPU write data
- O_CPU_ACK  out  1  one-cycle completion pulse
- O_CPU_RDATA  out  8  read data; valid on ack, held until the next CPU ack
- I_DMA_REQ, I_DMA_WE, I_DMA_ADDR[15:0], I_DMA_WDATA[7:0], O_DMA_ACK, O_DMA_RDATA[7:0]: same semantics as the CPU port, for DMA
- I_DMA_LOCK  in  1  DMA burst in progress; DMA gets priority
- O_WRAM_ADDR  out  16  address to the WRAM port
- O_WRAM_WDATA  out  8  write data to the WRAM port
- O_WRAM_WE_L  out  1  active-low write strobe
- O_WRAM_RE_L  out  1  active-low read strobe
- I_WRAM_RDATA  in  8  read data from the WRAM port
- O_BUSY  out  1  high whenever the FSM is not IDLE

Behaviour:
- Reset values: O_WRAM_WE_L=1, O_WRAM_RE_L=1, O_WRAM_ADDR=0, O_WRAM_WDATA=0, both ACKs=0, both RDATA=0, O_BUSY=0, state=IDLE, burst_cnt=0, last_owner=DMA (so CPU wins the first tie).
- Reset asserted mid-access forces all outputs to these values immediately. The aborted access is never acked.
- FSM states:
  - IDLE: if any REQ is high, pick a winner. Latch owner, addr, wdata and we into registers. Go to STROBE.
  - STROBE (1 cycle): drive registered addr/wdata. Assert WE_L=0 if write, else RE_L=0. Go to WAIT.
  - WAIT: strobes high, addr held. Count READ_LATENCY cycles, then go to ACK.
  - ACK (1 cycle): pulse the owner's ACK. On a read, load the owner's RDATA from I_WRAM_RDATA. Go to IDLE.
- Outputs are registered. One access occupies READ_LATENCY+3 cycles, from the IDLE decision through ACK. The earliest re-grant is the cycle after ACK.
- Winner selection, evaluated in IDLE only:
  - Only one REQ high: grant it.
  - Both high, I_DMA_LOCK=1, burst_cnt<MAX_DMA_BURST: grant DMA.
  - Both high otherwise: round-robin; grant the port that is not last_owner.
- burst_cnt:
  - +1 on each DMA grant while I_DMA_LOCK=1; saturates at MAX_DMA_BURST.
  - Cleared on any CPU grant, and in any cycle where I_DMA_LOCK=0.
  - When burst_cnt=MAX_DMA_BURST and CPU is requesting, exactly one CPU access is granted, then DMA lock priority resumes.
- Write accesses: the owner's RDATA is unchanged; ACK still pulses.
- Requester fields are sampled only at grant. Changes afterwards do not affect the in-flight access.
- A REQ dropped before ACK is a protocol violation. The access still completes and ACK still pulses.
- A requester that keeps REQ high after its ACK is treated as a new request in the next IDLE cycle.
- O_WRAM_ADDR/WDATA hold their last value when idle. Strobes are low only in STROBE.

Decomposition:
- Shared header (alongside memdef.vh): state encodings IDLE/STROBE/WAIT/ACK, OWNER_CPU=0 / OWNER_DMA=1, default MAX_DMA_BURST.
- One natural sub-module: wram_arb_pick. Purely combinational; inputs are reqs, lock, burst_cnt, last_owner; outputs are grant_valid and grant_owner. This keeps the priority logic unit-testable.

Test Plan:
- Single CPU read of 0xC123, WRAM model returns 0x5A, READ_LATENCY=1: RE_L low exactly one cycle with addr 0xC123; O_CPU_ACK pulses 4 cycles after REQ is first sampled; O_CPU_RDATA=0x5A; O_DMA_ACK stays 0.
- CPU and DMA request in the same cycle, lock=0, both held high for 6 accesses: grants alternate CPU, DMA, CPU, DMA, CPU, DMA.
- lock=1, MAX_DMA_BURST=4, both REQs held: 4 DMA grants, 1 CPU grant, then 4 DMA grants again. burst_cnt returns to 0 after the CPU grant.
- DMA write 0xD010 <- 0x77, then I_DMA_WDATA changed one cycle after grant: WE_L pulse carries addr 0xD010, data 0x77; O_DMA_RDATA unchanged; ack pulses.
- I_RESET asserted during WAIT of a CPU read: strobes, ACKs and O_BUSY are 0/inactive immediately; no ack after release; the next request completes normally.
- READ_LATENCY=3, DMA read: ACK arrives 6 cycles after grant; I_WRAM_RDATA is captured in the ACK cycle only (a value changed one cycle earlier is not captured).
